// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the MMU data port.
// Each transaction runs IDLE -> ACCESS -> DONE, with a bounded wait on m_wait.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    // Request/ack handshake: a requester raises reqN together with addrN,
    // wdataN and weN and keeps all of them stable until the cycle after
    // ackN. ackN is a one-cycle pulse. errN is meaningful only while ackN
    // is high. A request dropped before it is granted is simply forgotten.
    input  logic              req0,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we0,
    output logic              ack0,
    output logic              err0,

    input  logic              req1,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we1,
    output logic              ack1,
    output logic              err1,

    output logic [DATA_W-1:0] rdata,

    output logic [DATA_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_rd,
    output logic              m_wd,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_wait,
    input  logic              m_segv,

    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              gnt_q;
    logic [7:0]        wcnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              m_rd_q;
    logic              m_wd_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              err0_q;
    logic              err1_q;

    logic              any_req;
    logic              gnt_d;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              timeout_hit;

    // gnt_q doubles as the last-granted pointer: it only changes when a
    // new transaction leaves IDLE, so the two are always the same value.
    always_comb begin
        gnt_d = gnt_q;
        if (req0 && req1) begin
            gnt_d = ~gnt_q;
        end else if (req0) begin
            gnt_d = 1'b0;
        end else if (req1) begin
            gnt_d = 1'b1;
        end
    end

    assign any_req     = req0 | req1;
    assign sel_addr    = gnt_d ? addr1  : addr0;
    assign sel_wdata   = gnt_d ? wdata1 : wdata0;
    assign sel_we      = gnt_d ? we1    : we0;
    assign timeout_hit = (wcnt_q == TIMEOUT_M1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gnt_q   <= 1'b1;
            wcnt_q  <= '0;
            rdata_q <= '0;
            m_rd_q  <= 1'b0;
            m_wd_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    err0_q <= 1'b0;
                    err1_q <= 1'b0;
                    if (any_req) begin
                        gnt_q   <= gnt_d;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        we_q    <= sel_we;
                        wcnt_q  <= '0;
                        m_rd_q  <= ~sel_we;
                        m_wd_q  <= sel_we;
                        state_q <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!m_wait) begin
                        if (!we_q) begin
                            rdata_q <= m_data;
                        end
                        ack0_q  <= ~gnt_q;
                        ack1_q  <= gnt_q;
                        err0_q  <= ~gnt_q & m_segv;
                        err1_q  <= gnt_q & m_segv;
                        m_rd_q  <= 1'b0;
                        m_wd_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                        // Stuck MMU: give up, report an error, keep rdata.
                        if (timeout_hit) begin
                            ack0_q  <= ~gnt_q;
                            ack1_q  <= gnt_q;
                            err0_q  <= ~gnt_q;
                            err1_q  <= gnt_q;
                            m_rd_q  <= 1'b0;
                            m_wd_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    err0_q  <= 1'b0;
                    err1_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    err0_q  <= 1'b0;
                    err1_q  <= 1'b0;
                    m_rd_q  <= 1'b0;
                    m_wd_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign rdata       = rdata_q;
    assign m_addr      = addr_q;
    assign m_data_in   = wdata_q;
    assign m_rd        = m_rd_q;
    assign m_wd        = m_wd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, waited writes, segv, timeout,
// round-robin order and reset during an access.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk;
  logic reset_n;
  logic req0, req1, we0, we1;
  logic [DW-1:0] addr0, addr1, wdata0, wdata1;
  logic ack0, ack1, err0, err1;
  logic [DW-1:0] rdata, m_addr, m_data_in, m_data, m_data_v;
  logic m_rd, m_wd, m_wait, m_segv;
  logic [1:0] dbg_state;
  logic use_model;
  logic glitch0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  assign m_data = use_model ? (m_addr ^ K) : m_data_v;

  mem_arbiter #(.DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1), .err1(err1),
    .rdata(rdata), .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wd(m_wd),
    .m_data(m_data), .m_wait(m_wait), .m_segv(m_segv), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: raise one request, service m_wait, wait (bounded) for its ack
  task automatic run_req(input int id, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input int wait_n,
                         output int lat, output int wd_cyc, output int rd_cyc,
                         output logic ack_err, output logic other_ack);
    int acc;
    bit got;
    acc = 0; got = 0; lat = 0; wd_cyc = 0; rd_cyc = 0;
    ack_err = 1'b0; other_ack = 1'b0;
    m_wait = 1'b0;
    if (id == 0) begin
      req0 = 1'b1; addr0 = a; wdata0 = d; we0 = we;
    end else begin
      req1 = 1'b1; addr1 = a; wdata1 = d; we1 = we;
    end
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (m_rd) rd_cyc++;
      if (m_wd) wd_cyc++;
      if ((id == 0) ? ack1 : ack0) other_ack = 1'b1;
      if ((id == 0) ? ack0 : ack1) begin
        got = 1;
        lat = c;
        ack_err = (id == 0) ? err0 : err1;
      end else begin
        if (m_rd || m_wd) begin
          acc++;
          m_wait = (acc <= wait_n);
        end
        if (glitch0) req0 = (acc == 1);
      end
    end
    if (!got) check("ack_seen", 32'd0, 32'd1);
    m_wait = 1'b0;
    if (glitch0) req0 = 1'b0;
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    m_wait = 1'b0; m_segv = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lat, wdc, rdc, nacks, gid;
    logic e, oth, any_ack;
    logic [31:0] exp_id;

    reset_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    m_data_v = '0; m_wait = 1'b0; m_segv = 1'b0;
    use_model = 1'b0; glitch0 = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_outs", {26'd0, ack0, ack1, err0, err1, m_rd, m_wd}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", m_addr, 32'd0);
    check("rst_mdin", m_data_in, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // zero-wait read
    m_data_v = 32'hDEAD_BEEF;
    run_req(0, 32'h20, 32'h0, 1'b0, 0, lat, wdc, rdc, e, oth);
    check("rd_latency", lat, 32'd2);
    check("rd_mrd_cycles", rdc, 32'd1);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_err", {31'd0, e}, 32'd0);
    check("rd_other_ack", {31'd0, oth}, 32'd0);
    @(negedge clk);
    check("rd_back_idle", {30'd0, dbg_state}, 32'd0);
    check("rd_ack_pulse", {30'd0, ack0, ack1}, 32'd0);

    // waited write from requester 1, with a short-lived req0 that must be dropped
    m_data_v = 32'h5555_AAAA;
    glitch0 = 1'b1;
    run_req(1, 32'h30, 32'h1234_5678, 1'b1, 3, lat, wdc, rdc, e, oth);
    glitch0 = 1'b0;
    check("wr_mwd_cycles", wdc, 32'd4);
    check("wr_mrd_cycles", rdc, 32'd0);
    check("wr_latency", lat, 32'd5);
    check("wr_err", {31'd0, e}, 32'd0);
    check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
    check("wr_other_ack", {31'd0, oth}, 32'd0);
    any_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_ack = any_ack | ack0 | ack1;
    end
    check("drop_no_ack", {31'd0, any_ack}, 32'd0);
    check("drop_idle", {30'd0, dbg_state}, 32'd0);

    // segv read
    m_data_v = 32'h0BAD_F00D;
    m_segv = 1'b1;
    run_req(0, 32'h0, 32'h0, 1'b0, 0, lat, wdc, rdc, e, oth);
    m_segv = 1'b0;
    check("segv_err", {31'd0, e}, 32'd1);
    check("segv_latency", lat, 32'd2);
    @(negedge clk);

    // m_wait stuck high -> timeout after 16 ACCESS cycles
    m_data_v = 32'h1111_1111;
    run_req(0, 32'h44, 32'h0, 1'b0, 1000, lat, wdc, rdc, e, oth);
    check("to_access_cycles", rdc, 32'd16);
    check("to_latency", lat, 32'd17);
    check("to_err", {31'd0, e}, 32'd1);
    check("to_rdata_kept", rdata, 32'h0BAD_F00D);
    @(negedge clk);
    check("to_back_idle", {30'd0, dbg_state}, 32'd0);
    check("to_mrd_low", {31'd0, m_rd}, 32'd0);

    // simultaneous held requests after reset alternate 0,1,0,1
    apply_reset();
    use_model = 1'b1;
    exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
    req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0;
    req1 = 1'b1; addr1 = 32'h200; we1 = 1'b0;
    nacks = 0;
    for (int c = 0; c < 60 && nacks < 4; c++) begin
      @(negedge clk);
      if (ack0 && ack1) check("rr_dual_ack", 32'd1, 32'd0);
      if (ack0 || ack1) begin
        gid = ack1 ? 1 : 0;
        exp_id = exp_q.pop_front();
        check("rr_order", gid, exp_id);
        check("rr_rdata", rdata, ((gid == 1) ? 32'h200 : 32'h100) ^ K);
        nacks++;
        if (nacks == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    check("rr_count", nacks, 32'd4);
    use_model = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_idle", {30'd0, dbg_state}, 32'd0);

    // reset asserted mid-ACCESS aborts, held request re-served afterwards
    m_data_v = 32'h0000_0077;
    req1 = 1'b1; addr1 = 32'h40; we1 = 1'b0;
    m_wait = 1'b1;
    @(negedge clk);
    check("ra_in_access", {31'd0, m_rd}, 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("ra_mrd", {31'd0, m_rd}, 32'd0);
    check("ra_maddr", m_addr, 32'd0);
    check("ra_state", {30'd0, dbg_state}, 32'd0);
    any_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_ack = any_ack | ack0 | ack1 | m_rd;
    end
    check("ra_quiet", {31'd0, any_ack}, 32'd0);
    reset_n = 1'b1;
    run_req(1, 32'h40, 32'h0, 1'b0, 0, lat, wdc, rdc, e, oth);
    check("ra_reserve_lat", lat, 32'd2);
    check("ra_rdata", rdata, 32'h0000_0077);
    check("ra_err", {31'd0, e}, 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
